// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: datapath widths, reset/bubble defaults,
// fetch FSM encoding and the {pc, instr} entry carried through the output/skid registers.
// No logic beyond a PC alignment helper.
package if_fetch_unit_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC     = '0;
    localparam logic [ILEN-1:0] DEFAULT_BUBBLE_INSTR = '0;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits of a target are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: valid/ready request channel plus an in-order response strobe.
// Purely wiring; no latency of its own.
// Responses carry no ready: the requester must always be able to absorb one.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;

    // master: the fetch unit; slave: the instruction memory
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_fetch_unit_skid.sv
// One-entry {pc, instr} holding buffer for a response that arrives while ID is stalled.
// Load/consume take effect at the next clock edge; contents visible the cycle after load.
// No backpressure of its own: the owner must not issue a fetch while vld is high.
// Ports: clk, reset, load/load_dat, consume, clear -> vld/dat.
module if_fetch_unit_skid
    import if_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  fetch_entry_t load_dat,
    input  logic         consume,
    input  logic         clear,
    output logic         vld,
    output fetch_entry_t dat
);

    // clear (redirect) beats load, which beats consume: a load coincident with
    // a consume replaces the entry that was just moved to the output register.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
        end else if (consume) begin
            vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dat <= '0;
        end else if (load) begin
            dat <= load_dat;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches one word at a time from imem and presents it to IF/ID.
// Latency: request accept -> response cycle -> instruction on pc_out/instruction next cycle.
// Backpressure: id_stall holds the output register; a response caught behind a stall goes
// to the skid entry, and no new request is issued while that entry is occupied.
// Ports: clk, reset; imem (master side of the memory port); id_stall, redirect_valid/pc in;
// pc_out, instruction, if_id_write, if_id_flush out.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter logic [ILEN-1:0] BUBBLE_INSTR = DEFAULT_BUBBLE_INSTR
) (
    input  logic                 clk,
    input  logic                 reset,
    if_fetch_unit_if.master      imem,
    input  logic                 id_stall,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic [XLEN-1:0]      pc_out,
    output logic [ILEN-1:0]      instruction,
    output logic                 if_id_write,
    output logic                 if_id_flush
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q;
    logic            kill_q, kill_d;
    logic            out_vld_q, out_vld_d;
    fetch_entry_t    out_q, out_d;

    logic            skid_vld;
    fetch_entry_t    skid_dat;
    logic            skid_load, skid_consume, skid_clear;

    logic            req_fire;
    logic            inflight;
    logic            rsp_take;
    logic            consume;
    fetch_entry_t    rsp_entry;

    // kill_q marks a request whose response must be thrown away; no new request
    // may go out until that response has been seen, so one-outstanding still holds.
    assign imem.imem_req_valid = (state_q == S_REQ) && !skid_vld && !kill_q && !reset;
    assign imem.imem_req_addr  = pc_q;

    assign req_fire  = imem.imem_req_valid && imem.imem_req_ready;
    assign inflight  = (state_q == S_WAIT) || kill_q;
    assign rsp_take  = imem.imem_rsp_valid && (state_q == S_WAIT) && !kill_q && !redirect_valid;
    assign consume   = out_vld_q && !id_stall;
    assign rsp_entry = '{pc: inflight_pc_q, instr: imem.imem_rsp_data};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        out_vld_d    = out_vld_q;
        out_d        = out_q;
        skid_load    = 1'b0;
        skid_consume = 1'b0;
        skid_clear   = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                    pc_d    = pc_q + XLEN'(4);
                end
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (kill_q && imem.imem_rsp_valid) begin
            kill_d = 1'b0;
        end

        // Ordering: skid entry is always older than a same-cycle response.
        if (consume) begin
            if (skid_vld) begin
                out_d        = skid_dat;
                skid_consume = 1'b1;
                skid_load    = rsp_take;
            end else if (rsp_take) begin
                out_d = rsp_entry;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (!out_vld_q) begin
            if (rsp_take) begin
                out_d     = rsp_entry;
                out_vld_d = 1'b1;
            end
        end else begin
            skid_load = rsp_take;
        end

        // Redirect wins over everything. Anything still owed by memory after this
        // edge (a waiting request, or one accepted right now) becomes a kill.
        if (redirect_valid) begin
            pc_d       = align_pc(redirect_pc);
            out_vld_d  = 1'b0;
            skid_clear = 1'b1;
            state_d    = S_REQ;
            kill_d     = (inflight && !imem.imem_rsp_valid) || req_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
            out_vld_q     <= 1'b0;
            out_q         <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            if (req_fire) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    if_fetch_unit_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .load_dat (rsp_entry),
        .consume  (skid_consume),
        .clear    (skid_clear),
        .vld      (skid_vld),
        .dat      (skid_dat)
    );

    assign pc_out      = out_vld_q ? out_q.pc    : '0;
    assign instruction = out_vld_q ? out_q.instr : BUBBLE_INSTR;
    assign if_id_write = !id_stall;
    assign if_id_flush = redirect_valid;

    a_rsp_has_owner: assert property (@(posedge clk) disable iff (reset)
        imem.imem_rsp_valid |-> ((state_q == S_WAIT) || kill_q));

    a_req_aligned: assert property (@(posedge clk) disable iff (reset)
        imem.imem_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [31:0] BUBBLE = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] pc_out;
    logic [31:0] instruction;
    logic        if_id_write;
    logic        if_id_flush;

    always #5 clk = ~clk;

    if_fetch_unit_if imem ();

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_out         (pc_out),
        .instruction    (instruction),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush)
    );

    int checks = 0;
    int errors = 0;

    // drive values for the next cycle
    logic        d_reset, d_stall, d_redir, d_ready;
    logic [63:0] d_rpc;
    int          lat_lo, lat_hi;

    // memory model: at most one request held, answered after lat cycles
    logic        mem_busy;
    int          mem_cnt;
    logic [63:0] mem_addr;
    logic        rsp_drv;

    // program-order reference: the consumed stream is RESET_PC, +4, ... restarted at each redirect
    logic [63:0] exp_pc, exp_req;
    logic        prev_hold;
    logic [63:0] prev_pc;
    logic [31:0] prev_ins;
    int          n_cons, total_cons;

    // sampled outputs
    logic        s_req_v, s_fire, s_flush, s_write;
    logic [63:0] s_addr, s_pc;
    logic [31:0] s_ins;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return ((a[31:0] ^ a[63:32]) * 32'h9E37_79B1) | 32'h3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc    = RST_PC;
        exp_req   = RST_PC;
        prev_hold = 1'b0;
        n_cons    = 0;
    endtask

    task automatic tick();
        reset                = d_reset;
        id_stall             = d_stall;
        redirect_valid       = d_redir;
        redirect_pc          = d_rpc;
        imem.imem_req_ready  = d_ready;
        rsp_drv              = mem_busy && (mem_cnt == 1);
        imem.imem_rsp_valid  = rsp_drv;
        imem.imem_rsp_data   = rsp_drv ? mem_word(mem_addr) : $urandom;
        #1;
        s_req_v = imem.imem_req_valid;
        s_addr  = imem.imem_req_addr;
        s_pc    = pc_out;
        s_ins   = instruction;
        s_flush = if_id_flush;
        s_write = if_id_write;
        s_fire  = s_req_v && d_ready;

        if (d_reset) begin
            model_reset();
        end else begin
            chk("if_id_write", 64'(s_write), 64'(!d_stall));
            chk("if_id_flush", 64'(s_flush), 64'(d_redir));
            if (s_req_v) chk("req_align", 64'(s_addr[1:0]), 64'd0);
            if (s_fire) begin
                chk("one_outstanding", 64'(mem_busy && !rsp_drv), 64'd0);
                chk("req_addr_seq", s_addr, exp_req);
                exp_req = exp_req + 64'd4;
            end
            if (s_ins === BUBBLE) begin
                chk("bubble_pc", s_pc, 64'd0);
            end else if (prev_hold) begin
                chk("hold_pc", s_pc, prev_pc);
                chk("hold_ins", 64'(s_ins), 64'(prev_ins));
            end
            if (s_ins !== BUBBLE && !d_stall && !d_redir) begin
                chk("cons_pc", s_pc, exp_pc);
                chk("cons_ins", 64'(s_ins), 64'(mem_word(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                n_cons++;
                total_cons++;
            end
            prev_hold = (s_ins !== BUBBLE) && d_stall && !d_redir;
            prev_pc   = s_pc;
            prev_ins  = s_ins;
            if (d_redir) begin
                exp_pc  = d_rpc & ~64'd3;
                exp_req = d_rpc & ~64'd3;
            end
        end

        @(posedge clk);
        #1;
        if (d_reset) begin
            mem_busy = 1'b0;
        end else begin
            if (rsp_drv) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (s_fire) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(lat_hi, lat_lo);
                mem_addr = s_addr;
            end
        end
    endtask

    task automatic do_reset();
        d_reset = 1'b1; d_stall = 1'b0; d_redir = 1'b0; d_ready = 1'b1; d_rpc = '0;
        tick();
        tick();
        d_reset = 1'b0;
    endtask

    initial begin
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0; total_cons = 0;
        lat_lo = 1; lat_hi = 1;
        model_reset();

        // reset state
        d_reset = 1'b1; d_stall = 1'b0; d_redir = 1'b0; d_ready = 1'b1; d_rpc = '0;
        tick();
        tick();
        chk("rst_req_valid", 64'(s_req_v), 64'd0);
        chk("rst_pc_out", s_pc, 64'd0);
        chk("rst_instr", 64'(s_ins), 64'(BUBBLE));
        d_reset = 1'b0;
        tick();
        chk("rst_first_req", 64'(s_req_v), 64'd1);
        chk("rst_first_addr", s_addr, RST_PC);

        // T1: streaming, 1-cycle memory, no stall
        do_reset();
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 2) chk("t1_first_pc", s_pc, RST_PC);
        end
        chk("t1_count", 64'(n_cons), 64'd4);

        // T2: stall with a response in flight fills the skid entry
        do_reset();
        for (int k = 0; k < 9; k++) begin
            d_stall = (k >= 2 && k <= 4);
            tick();
            if (k == 4) begin
                chk("t2_skid_gate", 64'(s_req_v), 64'd0);
                chk("t2_hold_pc", s_pc, 64'd0);
                chk("t2_hold_ins", 64'(s_ins), 64'(mem_word(64'd0)));
            end
            if (k == 5) chk("t2_gate_release", 64'(s_req_v), 64'd0);
        end
        chk("t2_count", 64'(n_cons), 64'd3);
        d_stall = 1'b0;

        // T3: redirect while waiting on a 3-cycle memory
        lat_lo = 3; lat_hi = 3;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            d_redir = (k == 1);
            d_rpc   = 64'h100;
            tick();
            if (k == 1) chk("t3_flush_on", 64'(s_flush), 64'd1);
            if (k == 2) chk("t3_flush_off", 64'(s_flush), 64'd0);
            if (k == 2 || k == 3) chk("t3_kill_gate", 64'(s_req_v), 64'd0);
            if (k == 4) begin
                chk("t3_req_v", 64'(s_req_v), 64'd1);
                chk("t3_req_addr", s_addr, 64'h100);
                chk("t3_no_old", 64'(s_ins), 64'(BUBBLE));
            end
        end
        d_redir = 1'b0;

        // T4: redirect coinciding with the response
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            d_redir = (k == 1);
            d_rpc   = 64'h200;
            tick();
            if (k == 2) begin
                chk("t4_req_v", 64'(s_req_v), 64'd1);
                chk("t4_req_addr", s_addr, 64'h200);
                chk("t4_dropped", 64'(s_ins), 64'(BUBBLE));
            end
        end
        d_redir = 1'b0;

        // T5: unaligned target, then fetch across the top of the address space
        do_reset();
        for (int k = 0; k < 9; k++) begin
            d_redir = (k == 0 || k == 3);
            d_rpc   = (k == 0) ? 64'h103 : 64'hFFFF_FFFF_FFFF_FFFC;
            d_ready = !(k == 0 || k == 3);
            tick();
            if (k == 1) chk("t5_align", s_addr, 64'h100);
            if (k == 4) chk("t5_top_addr", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
            if (k == 6) begin
                chk("t5_wrap_addr", s_addr, 64'd0);
                chk("t5_top_pc", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);
            end
        end
        d_redir = 1'b0; d_ready = 1'b1;

        // T6: reset while waiting with the output register full
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin lat_lo = 3; lat_hi = 3; end
            d_stall = (k == 2 || k == 3);
            d_reset = (k == 3);
            tick();
            if (k == 3) chk("t6_rst_gate", 64'(s_req_v), 64'd0);
            if (k == 4) begin
                chk("t6_pc_out", s_pc, 64'd0);
                chk("t6_instr", 64'(s_ins), 64'(BUBBLE));
                chk("t6_restart", s_addr, RST_PC);
                chk("t6_restart_v", 64'(s_req_v), 64'd1);
            end
        end
        d_stall = 1'b0; d_reset = 1'b0;

        // randomized traffic against the program-order model
        lat_lo = 1; lat_hi = 4;
        do_reset();
        total_cons = 0;
        for (int k = 0; k < 4000; k++) begin
            d_stall = ($urandom_range(99, 0) < 30);
            d_ready = ($urandom_range(99, 0) < 70);
            d_redir = ($urandom_range(99, 0) < 4);
            d_rpc   = ($urandom_range(3, 0) == 0) ?
                      (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15, 0))) :
                      {$urandom, $urandom};
            d_reset = ($urandom_range(499, 0) == 0);
            tick();
        end
        chk("rand_progress", 64'(total_cons > 200), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
